// File: rtl/cnn_accel_reg_pkg.sv
// Shared definitions for the CNN accelerator AHB-Lite register slave:
// register word offsets, field bit positions, AHB HTRANS/HRESP encodings,
// and the state encodings of the layer and response FSMs.
package cnn_accel_reg_pkg;

  // Word offsets (sl_HADDR[7:2])
  localparam logic [5:0] OFF_FRAME_SIZE   = 6'd0;
  localparam logic [5:0] OFF_WIDTH_HEIGHT = 6'd1;
  localparam logic [5:0] OFF_DELAY_PARAMS = 6'd2;
  localparam logic [5:0] OFF_BASE_ADDRESS = 6'd3;
  localparam logic [5:0] OFF_LAYER_CONFIG = 6'd4;
  localparam logic [5:0] OFF_LAYER_START  = 6'd5;
  localparam logic [5:0] OFF_LAYER_DONE   = 6'd6;

  // Field positions
  localparam int unsigned WH_HEIGHT_LSB  = 16;
  localparam int unsigned DLY_HSYNC_LSB  = 12;
  localparam int unsigned BA_WEIGHT_W    = 20;
  localparam int unsigned BA_PARAM_LSB   = 20;
  localparam int unsigned BA_PARAM_W     = 12;
  localparam int unsigned LC_FIRST_BIT   = 0;
  localparam int unsigned LC_LAST_BIT    = 1;
  localparam int unsigned LC_CONV3X3_BIT = 2;
  localparam int unsigned LC_INDEX_LSB   = 4;
  localparam int unsigned LC_INDEX_W     = 4;
  localparam int unsigned LC_BIAS_LSB    = 8;
  localparam int unsigned LC_BIAS_W      = 5;
  localparam int unsigned LC_ACT_LSB     = 13;
  localparam int unsigned LC_ACT_W       = 3;

  // AHB encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    LS_IDLE = 2'b00,
    LS_RUN  = 2'b01,
    LS_DONE = 2'b10
  } layer_state_t;

  typedef enum logic [1:0] {
    RSP_OKAY = 2'b00,
    RSP_ERR1 = 2'b01,
    RSP_ERR2 = 2'b10
  } rsp_state_t;

  // Offsets beyond LAYER_DONE, and any write to the read-only LAYER_DONE
  function automatic logic is_illegal(input logic [5:0] off, input logic write);
    return (off > OFF_LAYER_DONE) || (write && (off == OFF_LAYER_DONE));
  endfunction

endpackage

// File: rtl/cnn_accel_ahb_slv.sv
// AHB-Lite register slave for the CNN accelerator: holds the frame and
// per-layer configuration and sequences layers through an IDLE/RUN/DONE FSM.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   sl_H*                        AHB-Lite slave inputs (HSIZE/HBURST ignored)
//   out_sl_HREADY/HRESP/HRDATA   AHB-Lite slave response
//   i_layer_done                 engine end-of-layer pulse
//   o_layer_start                one-cycle layer start pulse
//   o_frame_size .. o_is_conv3x3 configuration outputs
module cnn_accel_ahb_slv
  import cnn_accel_reg_pkg::*;
#(
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_SIZE  = 12,
  parameter int unsigned W_DELAY = 12
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                sl_HSEL,
  input  logic                sl_HREADY,
  input  logic [1:0]          sl_HTRANS,
  input  logic [2:0]          sl_HBURST,
  input  logic [2:0]          sl_HSIZE,
  input  logic [W_ADDR-1:0]   sl_HADDR,
  input  logic                sl_HWRITE,
  input  logic [W_DATA-1:0]   sl_HWDATA,
  output logic                out_sl_HREADY,
  output logic [1:0]          out_sl_HRESP,
  output logic [W_DATA-1:0]   out_sl_HRDATA,
  input  logic                i_layer_done,
  output logic                o_layer_start,
  output logic [2*W_SIZE:0]   o_frame_size,
  output logic [W_SIZE-1:0]   o_width,
  output logic [W_SIZE-1:0]   o_height,
  output logic [W_DELAY-1:0]  o_start_up_delay,
  output logic [W_DELAY-1:0]  o_hsync_delay,
  output logic [19:0]         o_base_addr_weight,
  output logic [11:0]         o_base_addr_param,
  output logic [2:0]          o_act_shift,
  output logic [4:0]          o_bias_shift,
  output logic [3:0]          o_layer_index,
  output logic                o_is_first_layer,
  output logic                o_is_last_layer,
  output logic                o_is_conv3x3
);

  logic         accept;
  logic [5:0]   a_off;
  logic         a_illegal;
  logic         dp_valid;
  logic         dp_write;
  logic [5:0]   dp_off;
  rsp_state_t   rsp_state;
  layer_state_t layer_state;
  logic         start_bit;
  logic         wr;
  logic         cfg_wr;
  logic         start_rise;
  logic         done_rd;
  logic         unused_sink;

  assign unused_sink = ^{sl_HSIZE, sl_HBURST, sl_HADDR, sl_HWDATA};

  assign accept    = sl_HSEL && sl_HREADY &&
                     ((sl_HTRANS == HTRANS_NONSEQ) || (sl_HTRANS == HTRANS_SEQ));
  assign a_off     = sl_HADDR[7:2];
  assign a_illegal = is_illegal(a_off, sl_HWRITE);

  // Only legal transfers ever reach the data phase as dp_valid, so an ERROR
  // transfer can never write or drive read data.
  assign wr         = dp_valid && dp_write;
  assign cfg_wr     = wr && (layer_state != LS_RUN);
  assign start_rise = wr && (dp_off == OFF_LAYER_START) && sl_HWDATA[0] &&
                      !start_bit && (layer_state != LS_RUN);
  // A done pulse coinciding with the read data phase is reported immediately.
  assign done_rd    = (layer_state == LS_DONE) ||
                      ((layer_state == LS_RUN) && i_layer_done);

  // Address-phase capture and response sequencing
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid      <= 1'b0;
      dp_write      <= 1'b0;
      dp_off        <= '0;
      rsp_state     <= RSP_OKAY;
      out_sl_HREADY <= 1'b1;
      out_sl_HRESP  <= HRESP_OKAY;
    end else begin
      dp_valid <= accept && !a_illegal;
      dp_write <= sl_HWRITE;
      dp_off   <= a_off;
      if (rsp_state == RSP_ERR1) begin
        rsp_state     <= RSP_ERR2;
        out_sl_HREADY <= 1'b1;
        out_sl_HRESP  <= HRESP_ERROR;
      end else if (accept && a_illegal) begin
        rsp_state     <= RSP_ERR1;
        out_sl_HREADY <= 1'b0;
        out_sl_HRESP  <= HRESP_ERROR;
      end else begin
        rsp_state     <= RSP_OKAY;
        out_sl_HREADY <= 1'b1;
        out_sl_HRESP  <= HRESP_OKAY;
      end
    end
  end

  // Register file and layer FSM
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      o_frame_size       <= '0;
      o_width            <= '0;
      o_height           <= '0;
      o_start_up_delay   <= '0;
      o_hsync_delay      <= '0;
      o_base_addr_weight <= '0;
      o_base_addr_param  <= '0;
      o_act_shift        <= '0;
      o_bias_shift       <= '0;
      o_layer_index      <= '0;
      o_is_first_layer   <= 1'b0;
      o_is_last_layer    <= 1'b0;
      o_is_conv3x3       <= 1'b0;
      start_bit          <= 1'b0;
      o_layer_start      <= 1'b0;
      layer_state        <= LS_IDLE;
    end else begin
      o_layer_start <= start_rise;
      if (cfg_wr) begin
        case (dp_off)
          OFF_FRAME_SIZE: o_frame_size <= sl_HWDATA[2*W_SIZE:0];
          OFF_WIDTH_HEIGHT: begin
            o_width  <= sl_HWDATA[W_SIZE-1:0];
            o_height <= sl_HWDATA[WH_HEIGHT_LSB +: W_SIZE];
          end
          OFF_DELAY_PARAMS: begin
            o_start_up_delay <= sl_HWDATA[W_DELAY-1:0];
            o_hsync_delay    <= sl_HWDATA[DLY_HSYNC_LSB +: W_DELAY];
          end
          OFF_BASE_ADDRESS: begin
            o_base_addr_weight <= sl_HWDATA[BA_WEIGHT_W-1:0];
            o_base_addr_param  <= sl_HWDATA[BA_PARAM_LSB +: BA_PARAM_W];
          end
          OFF_LAYER_CONFIG: begin
            o_is_first_layer <= sl_HWDATA[LC_FIRST_BIT];
            o_is_last_layer  <= sl_HWDATA[LC_LAST_BIT];
            o_is_conv3x3     <= sl_HWDATA[LC_CONV3X3_BIT];
            o_layer_index    <= sl_HWDATA[LC_INDEX_LSB +: LC_INDEX_W];
            o_bias_shift     <= sl_HWDATA[LC_BIAS_LSB +: LC_BIAS_W];
            o_act_shift      <= sl_HWDATA[LC_ACT_LSB +: LC_ACT_W];
          end
          default: ;
        endcase
      end
      if (wr && (dp_off == OFF_LAYER_START)) start_bit <= sl_HWDATA[0];
      case (layer_state)
        LS_IDLE, LS_DONE: if (start_rise) layer_state <= LS_RUN;
        LS_RUN:           if (i_layer_done) layer_state <= LS_DONE;
        default:          layer_state <= LS_IDLE;
      endcase
    end
  end

  // Read data, valid only in a legal read data phase
  always_comb begin
    out_sl_HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_off)
        OFF_FRAME_SIZE: out_sl_HRDATA[2*W_SIZE:0] = o_frame_size;
        OFF_WIDTH_HEIGHT: begin
          out_sl_HRDATA[W_SIZE-1:0]              = o_width;
          out_sl_HRDATA[WH_HEIGHT_LSB +: W_SIZE] = o_height;
        end
        OFF_DELAY_PARAMS: begin
          out_sl_HRDATA[W_DELAY-1:0]              = o_start_up_delay;
          out_sl_HRDATA[DLY_HSYNC_LSB +: W_DELAY] = o_hsync_delay;
        end
        OFF_BASE_ADDRESS: begin
          out_sl_HRDATA[BA_WEIGHT_W-1:0]          = o_base_addr_weight;
          out_sl_HRDATA[BA_PARAM_LSB +: BA_PARAM_W] = o_base_addr_param;
        end
        OFF_LAYER_CONFIG: begin
          out_sl_HRDATA[LC_FIRST_BIT]              = o_is_first_layer;
          out_sl_HRDATA[LC_LAST_BIT]               = o_is_last_layer;
          out_sl_HRDATA[LC_CONV3X3_BIT]            = o_is_conv3x3;
          out_sl_HRDATA[LC_INDEX_LSB +: LC_INDEX_W] = o_layer_index;
          out_sl_HRDATA[LC_BIAS_LSB +: LC_BIAS_W]   = o_bias_shift;
          out_sl_HRDATA[LC_ACT_LSB +: LC_ACT_W]     = o_act_shift;
        end
        OFF_LAYER_START: out_sl_HRDATA[0] = start_bit;
        OFF_LAYER_DONE:  out_sl_HRDATA[0] = done_rd;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_accel_ahb_slv.sv
// Self-checking bench for cnn_accel_ahb_slv: directed register/layer
// scenarios followed by randomized AHB traffic checked against a
// register-level reference model.
module tb_cnn_accel_ahb_slv;

  logic        HCLK;
  logic        HRESET;
  logic        sl_HSEL;
  logic        sl_HREADY;
  logic [1:0]  sl_HTRANS;
  logic [2:0]  sl_HBURST;
  logic [2:0]  sl_HSIZE;
  logic [31:0] sl_HADDR;
  logic        sl_HWRITE;
  logic [31:0] sl_HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic        i_layer_done;
  logic        o_layer_start;
  logic [24:0] o_frame_size;
  logic [11:0] o_width, o_height, o_start_up_delay, o_hsync_delay;
  logic [19:0] o_base_addr_weight;
  logic [11:0] o_base_addr_param;
  logic [2:0]  o_act_shift;
  logic [4:0]  o_bias_shift;
  logic [3:0]  o_layer_index;
  logic        o_is_first_layer, o_is_last_layer, o_is_conv3x3;

  cnn_accel_ahb_slv #(.W_ADDR(32), .W_DATA(32), .W_SIZE(12), .W_DELAY(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HTRANS(sl_HTRANS),
    .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE), .sl_HADDR(sl_HADDR),
    .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
    .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
    .out_sl_HRDATA(out_sl_HRDATA),
    .i_layer_done(i_layer_done), .o_layer_start(o_layer_start),
    .o_frame_size(o_frame_size), .o_width(o_width), .o_height(o_height),
    .o_start_up_delay(o_start_up_delay), .o_hsync_delay(o_hsync_delay),
    .o_base_addr_weight(o_base_addr_weight), .o_base_addr_param(o_base_addr_param),
    .o_act_shift(o_act_shift), .o_bias_shift(o_bias_shift),
    .o_layer_index(o_layer_index), .o_is_first_layer(o_is_first_layer),
    .o_is_last_layer(o_is_last_layer), .o_is_conv3x3(o_is_conv3x3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single slave on the bus: its HREADY is the bus HREADY
  assign sl_HREADY = out_sl_HREADY;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  always @(negedge HCLK) if (o_layer_start) pulse_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [6];
  bit          m_run;
  bit          m_done;

  function automatic logic [31:0] reg_mask(input int off);
    case (off)
      0: return 32'h01FF_FFFF;
      1: return 32'h0FFF_0FFF;
      2: return 32'h00FF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_FFF7;
      default: return 32'h0000_0001;
    endcase
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    m_run = 0;
    m_done = 0;
  endfunction

  function automatic void mdl_write(input int off, input logic [31:0] d);
    if (off <= 4) begin
      if (!m_run) m_reg[off] = d & reg_mask(off);
    end else if (off == 5) begin
      if (d[0] && !m_reg[5][0] && !m_run) begin
        m_run = 1;
        m_done = 0;
        exp_pulses++;
      end
      m_reg[5] = d & 32'h1;
    end
  endfunction

  function automatic logic [31:0] mdl_read(input int off);
    if (off == 6) return {31'd0, m_done};
    return m_reg[off];
  endfunction

  function automatic void mdl_done();
    if (m_run) begin
      m_run = 0;
      m_done = 1;
    end
  endfunction

  // ---------------- bus tasks (start and end at posedge+1) ----------------
  task automatic bus_idle();
    sl_HSEL = 0; sl_HTRANS = 2'b00; sl_HWRITE = 0;
    sl_HADDR = $urandom; sl_HWDATA = $urandom;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit done_dp, output int nwait, output logic first_ready,
                      output logic [1:0] first_resp, output logic [1:0] last_resp,
                      output logic [31:0] rdata);
    sl_HSEL = 1; sl_HTRANS = 2'b10; sl_HADDR = addr; sl_HWRITE = wr;
    sl_HSIZE = 3'($urandom); sl_HBURST = 3'($urandom);
    @(posedge HCLK); #1;
    sl_HSEL = 0; sl_HTRANS = 2'b00; sl_HWDATA = wdata; i_layer_done = done_dp;
    nwait = 0;
    @(negedge HCLK);
    first_ready = out_sl_HREADY;
    first_resp  = out_sl_HRESP;
    while (!out_sl_HREADY && nwait < 8) begin
      nwait++;
      @(posedge HCLK); #1;
      i_layer_done = 0;
      @(negedge HCLK);
    end
    rdata = out_sl_HRDATA;
    last_resp = out_sl_HRESP;
    @(posedge HCLK); #1;
    i_layer_done = 0;
    bus_idle();
  endtask

  // done_dp is only used with reads
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit done_dp);
    int nwait;
    logic fr;
    logic [1:0] r1, r2;
    logic [31:0] rd;
    int off;
    bit illegal;
    off = int'(addr[7:2]);
    illegal = (off > 6) || (wr && off == 6);
    xfer(wr, addr, wdata, done_dp, nwait, fr, r1, r2, rd);
    if (illegal) begin
      check_val($sformatf("err_ready1 @%0h", addr), {31'd0, fr}, 32'd0);
      check_val($sformatf("err_resp1 @%0h", addr), {30'd0, r1}, 32'd1);
      check_val($sformatf("err_resp2 @%0h", addr), {30'd0, r2}, 32'd1);
      check_val($sformatf("err_waits @%0h", addr), nwait, 32'd1);
    end else begin
      check_val($sformatf("ok_ready @%0h", addr), {31'd0, fr}, 32'd1);
      check_val($sformatf("ok_resp @%0h", addr), {30'd0, r1}, 32'd0);
      if (wr) mdl_write(off, wdata);
      else begin
        if (done_dp) mdl_done();
        check_val($sformatf("rdata @%0h", addr), rd, mdl_read(off));
      end
    end
  endtask

  task automatic wr_rd(input int off, input logic [31:0] data);
    sl_HSEL = 1; sl_HTRANS = 2'b10; sl_HADDR = off << 2; sl_HWRITE = 1;
    @(posedge HCLK); #1;
    sl_HTRANS = 2'b11; sl_HWRITE = 0; sl_HWDATA = data;
    @(negedge HCLK);
    check_val("pipe_wr_ready", {31'd0, out_sl_HREADY}, 32'd1);
    check_val("pipe_wr_resp", {30'd0, out_sl_HRESP}, 32'd0);
    @(posedge HCLK); #1;
    bus_idle();
    mdl_write(off, data);
    @(negedge HCLK);
    check_val($sformatf("pipe_rd_data off%0d", off), out_sl_HRDATA, mdl_read(off));
    check_val("pipe_rd_resp", {30'd0, out_sl_HRESP}, 32'd0);
    @(posedge HCLK); #1;
  endtask

  task automatic noise();
    int k;
    k = $urandom_range(0, 2);
    sl_HSEL = (k != 0);
    sl_HTRANS = (k == 0) ? 2'b10 : ((k == 1) ? 2'b00 : 2'b01);
    sl_HWRITE = 1;
    sl_HADDR = $urandom_range(0, 6) << 2;
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    check_val("noise_ready", {31'd0, out_sl_HREADY}, 32'd1);
    check_val("noise_resp", {30'd0, out_sl_HRESP}, 32'd0);
    @(posedge HCLK); #1;
  endtask

  task automatic pulse_done();
    i_layer_done = 1;
    @(posedge HCLK); #1;
    i_layer_done = 0;
    mdl_done();
  endtask

  task automatic check_outputs();
    @(negedge HCLK); #1;
    check_val("o_frame_size", o_frame_size, m_reg[0] & 32'h1FF_FFFF);
    check_val("o_width", o_width, m_reg[1] & 32'hFFF);
    check_val("o_height", o_height, (m_reg[1] >> 16) & 32'hFFF);
    check_val("o_start_up_delay", o_start_up_delay, m_reg[2] & 32'hFFF);
    check_val("o_hsync_delay", o_hsync_delay, (m_reg[2] >> 12) & 32'hFFF);
    check_val("o_base_addr_weight", o_base_addr_weight, m_reg[3] & 32'hF_FFFF);
    check_val("o_base_addr_param", o_base_addr_param, m_reg[3] >> 20);
    check_val("o_is_first_layer", o_is_first_layer, m_reg[4] & 32'h1);
    check_val("o_is_last_layer", o_is_last_layer, (m_reg[4] >> 1) & 32'h1);
    check_val("o_is_conv3x3", o_is_conv3x3, (m_reg[4] >> 2) & 32'h1);
    check_val("o_layer_index", o_layer_index, (m_reg[4] >> 4) & 32'hF);
    check_val("o_bias_shift", o_bias_shift, (m_reg[4] >> 8) & 32'h1F);
    check_val("o_act_shift", o_act_shift, (m_reg[4] >> 13) & 32'h7);
    check_val("layer_start_pulses", pulse_cnt, exp_pulses);
    @(posedge HCLK); #1;
  endtask

  task automatic apply_reset();
    HRESET = 1;
    bus_idle();
    i_layer_done = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); #1;
    check_val("rst_hready", {31'd0, out_sl_HREADY}, 32'd1);
    check_val("rst_hresp", {30'd0, out_sl_HRESP}, 32'd0);
    check_val("rst_hrdata", out_sl_HRDATA, 32'd0);
    check_val("rst_layer_start", {31'd0, o_layer_start}, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 0;
    mdl_reset();
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, off;
    sl_HSIZE = 3'b010; sl_HBURST = 3'b000;
    HRESET = 1;
    bus_idle();
    i_layer_done = 0;
    mdl_reset();
    @(posedge HCLK); #1;
    apply_reset();

    // done outside RUN is ignored
    pulse_done();
    do_access(0, 32'h18, 0, 0);

    // configuration writes and readback
    do_access(1, 32'h00, 32'h0000_4000, 0);
    do_access(1, 32'h04, 32'h0080_0080, 0);
    do_access(1, 32'h08, 32'h000A_00C8, 0);
    do_access(0, 32'h00, 0, 0);
    do_access(0, 32'h04, 0, 0);
    do_access(0, 32'h08, 0, 0);
    check_val("dir_width", o_width, 32'd128);
    check_val("dir_height", o_height, 32'd128);
    check_val("dir_startup", o_start_up_delay, 32'd200);
    check_val("dir_hsync", o_hsync_delay, 32'd160);

    // layer configuration
    do_access(1, 32'h10, 32'h0000_E904, 0);
    check_val("dir_act_shift", o_act_shift, 32'd7);
    check_val("dir_bias_shift", o_bias_shift, 32'd9);
    check_val("dir_layer_index", o_layer_index, 32'd0);
    check_val("dir_conv3x3", o_is_conv3x3, 32'd1);
    check_val("dir_first", o_is_first_layer, 32'd0);
    check_outputs();

    // layer start, polling, done, restart
    do_access(1, 32'h14, 32'h1, 0);
    do_access(1, 32'h14, 32'h0, 0);
    check_outputs();
    check_val("dir_one_pulse", pulse_cnt, 32'd1);
    repeat (3) do_access(0, 32'h18, 0, 0);
    pulse_done();
    do_access(0, 32'h18, 0, 0);
    check_val("dir_done_flag", out_sl_HRDATA, 32'd0);
    do_access(1, 32'h14, 32'h1, 0);
    do_access(1, 32'h14, 32'h1, 0);
    do_access(0, 32'h18, 0, 0);
    check_outputs();

    // writes while running are ignored
    do_access(1, 32'h00, 32'h0000_0100, 0);
    do_access(0, 32'h00, 0, 0);
    check_val("dir_run_frame", o_frame_size, 32'h4000);

    // done coincident with the LAYER_DONE read data phase
    do_access(0, 32'h18, 0, 1);

    // illegal accesses
    do_access(0, 32'h40, 0, 0);
    do_access(1, 32'h18, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 7; i++) do_access(0, i << 2, 0, 0);
    check_outputs();

    // back-to-back write then read
    wr_rd(3, 32'hDEAD_BEEF);
    wr_rd(4, 32'hFFFF_FFFF);
    check_outputs();

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        off = $urandom_range(0, 5);
        do_access(1, (32'($urandom) & 32'hFFFF_FF03) | (off << 2),
                  (off == 5) ? 32'($urandom_range(0, 1)) : 32'($urandom), 0);
      end else if (r < 62) begin
        off = $urandom_range(0, 6);
        do_access(0, off << 2, 0, $urandom_range(0, 7) == 0);
      end else if (r < 72) begin
        if ($urandom_range(0, 3) == 0) do_access(1, 32'h18, 32'($urandom), 0);
        else do_access($urandom_range(0, 1), $urandom_range(7, 63) << 2, 32'($urandom), 0);
      end else if (r < 82) begin
        pulse_done();
      end else if (r < 90) begin
        wr_rd($urandom_range(0, 5), ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                                               : 32'($urandom_range(0, 1)));
      end else begin
        noise();
      end
      check_outputs();
    end

    // reset while running
    if (m_run) pulse_done();
    do_access(1, 32'h14, 32'h0, 0);
    do_access(1, 32'h14, 32'h1, 0);
    check_val("pre_reset_run", {31'd0, m_run}, 32'd1);
    apply_reset();
    do_access(0, 32'h18, 0, 0);
    do_access(0, 32'h14, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
